voting_stream_tally: RTL and testbench

//  Sequential plurality-vote tallier. It accepts 2**M votes, one per handshake, on a

---
 rtl/voting_stream_tally.sv | 105 ++++++++++
 tb/tb_voting_stream_tally.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/voting_stream_tally.sv
// Streaming plurality-vote tallier: collects 2**M votes over a valid/ready handshake,
// scans one counter per candidate, and holds the winner until the consumer acknowledges.
module voting_stream_tally #(
  parameter int N = 3,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vote_valid,
  input  logic [N-1:0] vote,
  output logic         vote_ready,
  output logic         winner_valid,
  input  logic         winner_ready,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count
);

  localparam int NC = 2**N;

  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

  state_t         state_reg;
  logic [M:0]     cnt_reg [NC];
  logic [M-1:0]   vote_cnt_reg;
  logic [N-1:0]   index_reg;
  logic [N-1:0]   best_id_reg;
  logic [M:0]     best_count_reg;

  logic           accept;
  logic           clear;
  logic [M:0]     scan_cnt;
  logic           scan_better;

  assign vote_ready  = (state_reg == COLLECT);
  assign accept      = vote_valid && (state_reg == COLLECT);
  assign clear       = (state_reg == DONE) && winner_ready;
  assign scan_cnt    = cnt_reg[index_reg];
  // Strictly-greater keeps the lower id on ties, since ids are scanned in ascending order.
  assign scan_better = (scan_cnt > best_count_reg);

  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (clear) begin
          cnt_reg[gi] <= '0;
        end else if (accept && (vote == N'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= COLLECT;
      vote_cnt_reg   <= '0;
      index_reg      <= '0;
      best_id_reg    <= '0;
      best_count_reg <= '0;
      winner         <= '0;
      winner_count   <= '0;
      winner_valid   <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            vote_cnt_reg <= vote_cnt_reg + 1'b1;
            // The vote counter wraps to zero exactly as the round completes.
            if (vote_cnt_reg == '1) begin
              state_reg      <= SCAN;
              index_reg      <= '0;
              best_id_reg    <= '0;
              best_count_reg <= '0;
            end
          end
        end
        SCAN: begin
          if (scan_better) begin
            best_id_reg    <= index_reg;
            best_count_reg <= scan_cnt;
          end
          index_reg <= index_reg + 1'b1;
          if (index_reg == '1) begin
            state_reg    <= DONE;
            winner_valid <= 1'b1;
            winner       <= scan_better ? index_reg : best_id_reg;
            winner_count <= scan_better ? scan_cnt : best_count_reg;
          end
        end
        DONE: begin
          if (winner_ready) begin
            state_reg    <= COLLECT;
            winner_valid <= 1'b0;
            vote_cnt_reg <= '0;
            index_reg    <= '0;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_voting_stream_tally.sv
// Directed bench for voting_stream_tally: inputs driven and outputs sampled on the
// falling edge, each comparison an immediate assertion.
module tb_voting_stream_tally;

  localparam int N = 3;
  localparam int M = 5;

  logic         clk;
  logic         rst;
  logic         vote_valid;
  logic [N-1:0] vote;
  logic         vote_ready;
  logic         winner_valid;
  logic         winner_ready;
  logic [N-1:0] winner;
  logic [M:0]   winner_count;

  int checks;
  int failures;

  voting_stream_tally #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .vote_valid   (vote_valid),
    .vote         (vote),
    .vote_ready   (vote_ready),
    .winner_valid (winner_valid),
    .winner_ready (winner_ready),
    .winner       (winner),
    .winner_count (winner_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one vote at a falling edge, preceded by `gap` idle cycles.
  task automatic send_vote(input logic [N-1:0] v, input int gap, input string tag);
    vote_valid = 1'b0;
    repeat (gap) @(negedge clk);
    check({tag, "_ready"}, 32'(vote_ready), 32'd1);
    vote_valid = 1'b1;
    vote       = v;
    @(negedge clk);
  endtask

  // Wait (bounded) for the result; vote_ready must stay low meanwhile.
  task automatic wait_result(input string tag, input int exp_w, input int exp_c);
    vote_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (winner_valid === 1'b1) break;
      check({tag, "_scan_ready"}, 32'(vote_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(winner_valid), 32'd1);
    check({tag, "_done_ready"}, 32'(vote_ready), 32'd0);
    check({tag, "_winner"}, 32'(winner), 32'(exp_w));
    check({tag, "_count"}, 32'(winner_count), 32'(exp_c));
  endtask

  task automatic ack(input string tag);
    winner_ready = 1'b1;
    @(negedge clk);
    winner_ready = 1'b0;
    check({tag, "_ack_valid"}, 32'(winner_valid), 32'd0);
    check({tag, "_ack_ready"}, 32'(vote_ready), 32'd1);
  endtask

  int seq1 [32] = '{5,7,5,4,0,7,0,5,3,3,1,2,2,1,4,2,3,5,6,0,5,5,7,1,6,3,5,5,3,1,7,2};

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    vote_valid   = 1'b0;
    vote         = '0;
    winner_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(winner_valid), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_count", 32'(winner_count), 32'd0);
    check("rst_ready", 32'(vote_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: mixed votes, valid held high, exact latency
    for (int i = 0; i < 32; i++) send_vote(3'(seq1[i]), 0, "t1");
    vote_valid = 1'b0;
    check("t1_scan_ready", 32'(vote_ready), 32'd0);
    repeat (7) @(negedge clk);
    check("t1_valid_at7", 32'(winner_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_at8", 32'(winner_valid), 32'd1);
    check("t1_winner", 32'(winner), 32'd5);
    check("t1_count", 32'(winner_count), 32'd8);
    ack("t1");

    // 2: all votes to 7 with random gaps
    for (int i = 0; i < 32; i++) send_vote(3'd7, int'($urandom_range(0, 3)), "t2");
    wait_result("t2", 7, 32);
    ack("t2");

    // 3: tie between 6 and 2, lower id wins
    for (int i = 0; i < 32; i++) send_vote((i < 16) ? 3'd6 : 3'd2, 0, "t3");
    wait_result("t3", 2, 16);
    ack("t3");

    // 4: uniform distribution
    for (int i = 0; i < 32; i++) send_vote(3'(i % 8), 0, "t4");
    wait_result("t4", 0, 4);

    // 5: hold in DONE with stray vote_valid pulses, then a fresh round
    for (int i = 0; i < 20; i++) begin
      vote_valid = (i % 2 == 0);
      vote       = 3'd1;
      @(negedge clk);
      check("t5_hold_valid", 32'(winner_valid), 32'd1);
      check("t5_hold_winner", 32'(winner), 32'd0);
      check("t5_hold_count", 32'(winner_count), 32'd4);
      check("t5_hold_ready", 32'(vote_ready), 32'd0);
    end
    vote_valid = 1'b0;
    ack("t5");
    for (int i = 0; i < 32; i++) send_vote(3'd3, 0, "t5b");
    wait_result("t5b", 3, 32);
    ack("t5b");

    // 6: asynchronous reset mid-collect
    for (int i = 0; i < 10; i++) send_vote(3'd1, 0, "t6");
    vote_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(winner_valid), 32'd0);
    check("t6_rst_winner", 32'(winner), 32'd0);
    check("t6_rst_count", 32'(winner_count), 32'd0);
    check("t6_rst_ready", 32'(vote_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) send_vote(3'd4, 0, "t6b");
    wait_result("t6b", 4, 32);
    ack("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
